// File: rtl/source_sram_tile_reader.sv
// Streams a rows x cols tile of operands out of an SRAM read port onto a valid/ready
// stream. A credit check on FIFO occupancy plus the in-flight read keeps stalls lossless.
module source_sram_tile_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       rows_i,
  input  logic [15:0]       cols_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] sram_address_o,
  output logic              sram_chipselect_o,
  output logic              sram_write_o,
  output logic [1:0]        sram_byteenable_o,
  input  logic [DATA_W-1:0] sram_readdata_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_col_o,
  output logic              out_last_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] OCC_LIM = (CW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last_col;
    logic              last;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_ptr_q, stride_q;
  logic [15:0]       rows_q, cols_q, col_q, row_q;
  logic              inflight_q, tag_lc_q, tag_l_q;
  entry_t            mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [CW:0]       occ;
  logic              issue, push, pop, accept, at_last_col, at_last;
  entry_t            head;

  assign occ         = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};
  assign at_last_col = (col_q == cols_q - 16'd1);
  assign at_last     = at_last_col && (row_q == rows_q - 16'd1);
  assign accept      = (state_q == IDLE) && start_i && !abort_i;
  assign push        = inflight_q;
  assign pop         = out_valid_o && out_ready_i;
  // The pop of this cycle is counted so DRAIN can leave right after the last handshake.
  assign cnt_d       = abort_i ? '0 : cnt_q + CW'(push) - CW'(pop);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = (rows_i == 16'd0 || cols_i == 16'd0) ? DRAIN : ISSUE;
        ISSUE:   if (issue && at_last) state_d = DRAIN;
        DRAIN:   if (cnt_d == '0 && !issue) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy_o            = (state_q != IDLE);
    issue             = (state_q == ISSUE) && !abort_i && (occ <= OCC_LIM);
    sram_chipselect_o = issue;
    done_d            = (state_q == DRAIN) && (state_d == IDLE) && !abort_i;
  end

  assign sram_address_o    = row_ptr_q + col_q[ADDR_W-1:0];
  assign sram_write_o      = 1'b0;
  assign sram_byteenable_o = 2'b11;
  assign done_o            = done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      tag_lc_q   <= 1'b0;
      tag_l_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      row_ptr_q  <= '0;
      stride_q   <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      done_q <= done_d;
      cnt_q  <= cnt_d;
      if (abort_i) begin
        inflight_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        inflight_q <= issue;
        tag_lc_q   <= at_last_col;
        tag_l_q    <= at_last;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (accept) begin
        row_ptr_q <= base_addr_i;
        stride_q  <= stride_i;
        rows_q    <= rows_i;
        cols_q    <= cols_i;
        col_q     <= '0;
        row_q     <= '0;
      end else if (issue) begin
        if (at_last_col) begin
          col_q     <= '0;
          row_q     <= row_q + 16'd1;
          row_ptr_q <= row_ptr_q + stride_q;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push && !abort_i && !reset_i)
      mem_q[wr_ptr_q] <= '{data: sram_readdata_i, last_col: tag_lc_q, last: tag_l_q};
  end

  assign head           = mem_q[rd_ptr_q];
  assign out_valid_o    = (cnt_q != '0);
  assign out_data_o     = out_valid_o ? head.data : '0;
  assign out_last_col_o = out_valid_o && head.last_col;
  assign out_last_o     = out_valid_o && head.last;

endmodule

// File: tb/tb_source_sram_tile_reader.sv
// Randomized bench for source_sram_tile_reader: a tile-level model (address list and
// expected word queue) is checked against the stream every cycle, plus literal anchors.
module tb_source_sram_tile_reader;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, out_ready_i = 1'b1;
  logic [14:0] base_addr_i = '0, stride_i = '0;
  logic [15:0] rows_i = '0, cols_i = '0;
  logic [15:0] sram_readdata_i = '0;
  logic        busy_o, done_o, sram_chipselect_o, sram_write_o;
  logic [14:0] sram_address_o;
  logic [1:0]  sram_byteenable_o;
  logic [15:0] out_data_o;
  logic        out_valid_o, out_last_col_o, out_last_o;

  typedef struct {
    logic [15:0] d;
    logic        lc;
    logic        l;
  } wexp_t;

  int          n_vec = 0, n_err = 0, cyc = 0;
  int unsigned rdy_pct = 100;
  int          lit_mode = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  wexp_t       exp_w[$];
  logic [14:0] exp_a[$];
  int          outstanding = 0, t0 = 0, hs_idx = 0, cs_idx = 0, wd = 0;
  logic        empty_pend = 1'b0, rst_chk = 1'b0, prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_lc = 1'b0, prev_l = 1'b0;
  logic [15:0] lit1 [6] = '{16'h0010, 16'h0011, 16'h0012, 16'h0018, 16'h0019, 16'h001A};
  logic [14:0] lit2 [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};

  always #5 clk = ~clk;

  source_sram_tile_reader dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .rows_i(rows_i), .cols_i(cols_i), .stride_i(stride_i),
    .busy_o(busy_o), .done_o(done_o), .sram_address_o(sram_address_o),
    .sram_chipselect_o(sram_chipselect_o), .sram_write_o(sram_write_o),
    .sram_byteenable_o(sram_byteenable_o), .sram_readdata_i(sram_readdata_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_col_o(out_last_col_o), .out_last_o(out_last_o)
  );

  // SRAM holds mem[a] = a; unrequested cycles return noise.
  always @(posedge clk)
    sram_readdata_i <= sram_chipselect_o ? {1'b0, sram_address_o} : 16'($urandom);

  initial forever begin
    @(posedge clk); #1;
    out_ready_i = ($urandom_range(0, 99) < rdy_pct);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic build(input logic [14:0] b, input logic [15:0] r, input logic [15:0] c,
                       input logic [14:0] s);
    wexp_t w;
    logic [14:0] a;
    for (int ri = 0; ri < int'(r); ri++)
      for (int ci = 0; ci < int'(c); ci++) begin
        a = 15'(int'(b) + ri * int'(s) + ci);
        w.d = {1'b0, a};
        w.lc = (ci == int'(c) - 1);
        w.l = w.lc && (ri == int'(r) - 1);
        exp_a.push_back(a);
        exp_w.push_back(w);
      end
  endtask

  always @(negedge clk) begin : cmp
    logic hs, nb, nd;
    wexp_t w;
    if (rst_chk) begin
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_valid", int'(out_valid_o), 0);
      chk("rst_last_col", int'(out_last_col_o), 0);
      chk("rst_last", int'(out_last_o), 0);
      chk("rst_data", int'(out_data_o), 0);
      chk("rst_cs", int'(sram_chipselect_o), 0);
      chk("rst_addr", int'(sram_address_o), 0);
    end
    chk("busy", int'(busy_o), int'(m_busy));
    chk("done", int'(done_o), int'(m_done));
    chk("sram_write", int'(sram_write_o), 0);
    chk("sram_be", int'(sram_byteenable_o), 3);
    if (!m_busy) chk("idle_valid", int'(out_valid_o), 0);
    if (prev_stall) begin
      chk("stall_valid", int'(out_valid_o), 1);
      chk("stall_data", int'(out_data_o), int'(prev_data));
      chk("stall_tags", int'({out_last_col_o, out_last_o}), int'({prev_lc, prev_l}));
    end
    if (out_valid_o) begin
      if (exp_w.size() == 0) chk("spurious_valid", int'(out_valid_o), 0);
      else begin
        chk("data", int'(out_data_o), int'(exp_w[0].d));
        chk("last_col", int'(out_last_col_o), int'(exp_w[0].lc));
        chk("last", int'(out_last_o), int'(exp_w[0].l));
      end
    end
    if (sram_chipselect_o) begin
      if (exp_a.size() == 0) chk("spurious_cs", int'(sram_chipselect_o), 0);
      else chk("addr", int'(sram_address_o), int'(exp_a[0]));
      chk("cs_room", outstanding, (outstanding <= 2) ? outstanding : 2);
      if (lit_mode == 2 && cs_idx < 4) chk("lit_addr", int'(sram_address_o), int'(lit2[cs_idx]));
      cs_idx++;
    end
    hs = out_valid_o && out_ready_i;
    if (hs && lit_mode == 1 && hs_idx < 6) begin
      chk("lit_data", int'(out_data_o), int'(lit1[hs_idx]));
      chk("lit_hs_cycle", cyc - t0, 3 + hs_idx);
      chk("lit_tags", int'({out_last_col_o, out_last_o}),
          (hs_idx == 5) ? 3 : (hs_idx == 2) ? 2 : 0);
    end
    if (done_o && lit_mode == 1) chk("lit_done_cycle", cyc - t0, 9);
    if (done_o && lit_mode == 2) chk("lit_wrap_done_cycle", cyc - t0, 7);
    if (done_o && lit_mode == 3) chk("lit_empty_done_cycle", cyc - t0, 2);
    if (busy_o && lit_mode == 3) chk("lit_empty_busy_cycle", cyc - t0, 1);

    if (m_busy) wd++; else wd = 0;
    if (wd == 500) chk("timeout_busy", int'(busy_o), 0);

    nb = m_busy;
    nd = 1'b0;
    if (sram_chipselect_o) begin
      if (exp_a.size() != 0) void'(exp_a.pop_front());
      outstanding++;
    end
    if (hs && exp_w.size() != 0) begin
      w = exp_w.pop_front();
      outstanding--;
      hs_idx++;
      if (w.l) begin nb = 1'b0; nd = 1'b1; end
    end
    if (m_busy && empty_pend) begin nb = 1'b0; nd = 1'b1; empty_pend = 1'b0; end
    if (start_i && !abort_i && !m_busy) begin
      t0 = cyc; hs_idx = 0; cs_idx = 0; nb = 1'b1;
      build(base_addr_i, rows_i, cols_i, stride_i);
      if (rows_i == 16'd0 || cols_i == 16'd0) empty_pend = 1'b1;
    end
    if (abort_i || reset_i) begin
      nb = 1'b0; nd = 1'b0; empty_pend = 1'b0; outstanding = 0;
      exp_a.delete(); exp_w.delete();
    end
    rst_chk    = reset_i;
    prev_stall = out_valid_o && !out_ready_i && !abort_i && !reset_i;
    prev_data  = out_data_o;
    prev_lc    = out_last_col_o;
    prev_l     = out_last_o;
    m_busy     = nb;
    m_done     = nd;
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [14:0] b, input logic [15:0] r, input logic [15:0] c,
                        input logic [14:0] s);
    base_addr_i = b; rows_i = r; cols_i = c; stride_i = s; start_i = 1'b1;
    step();
    start_i = 1'b0;
    base_addr_i = 15'($urandom); rows_i = 16'($urandom); cols_i = 16'($urandom);
    stride_i = 15'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy || busy_o) && n < 600) begin step(); n++; end
    if (n >= 600) begin abort_i = 1'b1; step(); abort_i = 1'b0; end
    step();
  endtask

  initial begin
    int mode, nhs;
    repeat (3) step();
    reset_i = 1'b0;
    step();

    lit_mode = 1;
    launch(15'h0010, 16'd2, 16'd3, 15'd8);
    wait_idle();
    lit_mode = 0;

    // same tile under backpressure, with an ignored start mid-tile
    rdy_pct = 30;
    launch(15'h0010, 16'd2, 16'd3, 15'd8);
    repeat (3) step();
    base_addr_i = 15'h0500; rows_i = 16'd3; cols_i = 16'd3; start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_idle();
    rdy_pct = 100;

    lit_mode = 2;
    launch(15'h7FFE, 16'd1, 16'd4, 15'd0);
    wait_idle();

    lit_mode = 3;
    launch(15'h0005, 16'd0, 16'd5, 15'd1);
    wait_idle();
    launch(15'h0005, 16'd3, 16'd0, 15'd1);
    wait_idle();
    lit_mode = 0;

    // abort with the consumer stalled after three words
    launch(15'h0100, 16'd4, 16'd4, 15'h20);
    nhs = 0;
    for (int k = 0; k < 50 && nhs < 3; k++) begin
      @(negedge clk);
      if (out_valid_o && out_ready_i) nhs++;
    end
    rdy_pct = 0;
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    rdy_pct = 100;
    step();
    launch(15'h0200, 16'd1, 16'd2, 15'd1);
    wait_idle();

    launch(15'h0300, 16'd3, 16'd3, 15'd4);
    repeat (4) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 2));
      rdy_pct = (mode == 0) ? 30 : (mode == 1) ? 60 : 100;
      launch(15'($urandom), 16'($urandom_range(0, 4)), 16'($urandom_range(0, 5)),
             15'($urandom));
      mode = int'($urandom_range(0, 3));
      if (mode == 1) begin
        repeat ($urandom_range(1, 4)) step();
        base_addr_i = 15'($urandom); rows_i = 16'd2; cols_i = 16'd2; start_i = 1'b1;
        step();
        start_i = 1'b0;
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 8)) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
      end
      wait_idle();
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/source_sram_tile_reader.md
# source_sram_tile_reader

Sequencer that owns the second port of a 32K x 16 operand SRAM and streams a rectangular tile of 16-bit operands from it to an NPU datapath over a valid/ready interface. It generates row/column addresses from a latched descriptor (base, rows, cols, stride). It absorbs the SRAM's one-cycle read latency with a small credit-tracked FIFO, so a stalled consumer never loses a word. A start/busy/done handshake lets the layer controller launch one tile at a time.

## Interface
- ADDR_W, 15, SRAM word-address width
- DATA_W, 16, SRAM/stream data width
- FIFO_DEPTH, 4, output buffer depth (power of 2, >= 4)

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launch tile; sampled only in IDLE
- abort  in  1  cancel current tile; priority over start
- base_addr  in  ADDR_W  first word address
- rows  in  16  tile rows (0 = empty tile)
- cols  in  16  words per row (0 = empty tile)
- stride  in  ADDR_W  address step between row starts
- busy  out  1  high from cycle after accepted start until done/abort
- done  out  1  one-cycle pulse after last word handshaken
- sram_address  out  ADDR_W  read address
- sram_chipselect  out  1  read request this cycle
- sram_write  out  1  constant 0
- sram_byteenable  out  2  constant 2'b11
- sram_readdata  in  DATA_W  valid the cycle after the request cycle (unregistered RAM output)
- out_data  out  DATA_W  stream word
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts when valid & ready
- out_last_col  out  1  word is last of its row
- out_last  out  1  word is last of tile

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE → ISSUE on start & ~abort. Latch descriptor; row_ptr=base, col=0, row=0.
- IDLE → DRAIN on start & ~abort with rows==0 or cols==0. Reads issued: none.
- ISSUE: assert sram_chipselect when fifo_count + inflight <= FIFO_DEPTH-2.
  - On issue, set sram_address = row_ptr + col (mod 2^ADDR_W).
  - After issue, col increments. At col==cols-1, col resets to 0, row increments, and row_ptr += stride (mod 2^ADDR_W).
  - Tag each issued read with last_col/last flags; the tags travel with the data through the FIFO.
- ISSUE → DRAIN the cycle after the final address is issued.
- DRAIN → IDLE when FIFO is empty and inflight==0. Pulse done in the first IDLE cycle.
- inflight is a 1-bit flag. It is set on issue. If set, sram_readdata and tags are written into the FIFO the next cycle, and the flag clears unless re-issued.
- FIFO pops on out_valid & out_ready. Push and pop in the same cycle are legal; count is unchanged.
- abort (any state):
  - Next cycle: state IDLE, FIFO flushed, inflight cleared (the pending read's data is discarded).
  - busy low, out_valid low, no done pulse.
- start while busy is ignored. Descriptor inputs are ignored except at an accepted start.
- Address arithmetic wraps modulo 2^15. No error is flagged.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last_col=0, out_last=0, out_data=0, sram_chipselect=0, sram_address=0, sram_write=0, sram_byteenable=2'b11. State IDLE, FIFO empty, inflight=0.
- Reset has priority over abort and start, including mid-tile.
- Accepted start at cycle 0:
  - cycle 1: busy=1, first request on the SRAM port
  - cycle 2: data is on sram_readdata
  - cycle 3: out_valid=1
- With out_ready held high, throughput is 1 word/cycle. An N-word tile has its last handshake in cycle N+2 and the done pulse in cycle N+3. busy falls in the same cycle as done.
- Empty tile: busy=1 in cycle 1, done=1 with busy=0 in cycle 2, no chipselect.
- Backpressure: a request is never issued unless the FIFO has room for it and for any inflight word, so no word is dropped or duplicated. out_data and the tags remain stable while out_valid & ~out_ready.

## Test plan
- SRAM preloaded with mem[a]=a. Start with base=0x0010, rows=2, cols=3, stride=8, out_ready=1 → out_data 0x0010, 0x0011, 0x0012, 0x0018, 0x0019, 0x001A in cycles 3–8. out_last_col on words 3 and 6; out_last on word 6; done in cycle 9.
- Same tile with out_ready random at 30% → identical sequence and tags. sram_chipselect is never asserted while fifo_count+inflight > 2. out_data is held during every stall.
- base=0x7FFE, rows=1, cols=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001. Outputs are the matching values, then done.
- rows=0 (cols=5), then separately cols=0 → no chipselect; done in cycle 2; busy high only in cycle 1.
- abort on the cycle after the 3rd out handshake of a 4x4 tile, with out_ready=0 → next cycle out_valid=0 and busy=0, no done. A new start of a 1x2 tile yields exactly its 2 words, with no stale data.
- reset pulsed mid-tile → all outputs at reset values the next cycle. A start during busy (without reset) leaves the sequence unchanged.
